aes_enc_scheduler: RTL and testbench
====================================

# aes_enc_scheduler

Sequencing and arbitration controller for the shared iterative AES-128 encryption round datapath. It accepts encryption jobs from two requesters through valid/ready handshakes and grants the datapath round-robin. It owns the state register and the round counter, so the round datapath stays purely combinational. It returns each ciphertext tagged with the requester ID on a valid/ready response channel.

## Interface
- ROUNDS, 10, number of cipher rounds after the initial whitening; legal range 1..15.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle when req0_valid is also high.
- req0_block  in  128  requester 0 plaintext.
- req0_key  in  128  requester 0 cipher key.
- req1_valid / req1_ready / req1_block / req1_key: same as requester 0, for requester 1.
- resp_valid  out  1  ciphertext available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that owns the response.
- resp_data  out  128  ciphertext.
- dp_state  out  128  current state, driven to the round datapath.
- dp_key  out  128  latched cipher key, driven to the key expander.
- dp_round  out  4  round index: 0 selects whitening (AddRoundKey only).
- dp_final  out  1  high when dp_round == ROUNDS; selects the round with no MixColumns.
- dp_result  in  128  combinational datapath output for (dp_state, dp_round, dp_final).
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: accepts one job.
  - RUN: one round per cycle.
  - DONE: holds the response until it is taken.
- Reset: FSM = IDLE, round = 0, last_grant = 1 (requester 0 wins first tie).
  - All outputs read 0 after reset: readies, resp_valid, resp_id, resp_data, dp_state, dp_key, dp_round, dp_final, busy.
- Grant (IDLE only, combinational):
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = (FSM==IDLE) & grant==N. It may depend on reqN_valid. Never both high together.
- Accept (IDLE, granted valid&ready):
  - state_reg <= block, key_reg <= key, id_reg <= N, last_grant <= N.
  - round <= 0, FSM -> RUN.
- RUN, each cycle:
  - state_reg <= dp_result.
  - If round == ROUNDS, FSM -> DONE; otherwise round <= round+1.
- DONE:
  - resp_valid = 1, resp_data = state_reg, resp_id = id_reg.
  - On resp_ready: FSM -> IDLE, round <= 0.
  - resp_data and resp_id hold stable while resp_ready is low.
- dp_state = state_reg, dp_key = key_reg, dp_round = round, dp_final = (FSM==RUN && round==ROUNDS).
- The controller buffers one job at a time. No acceptance while in RUN or DONE.
- Request inputs change freely outside the accept cycle. The latched copy is used.
- Reset mid-operation: the in-flight job is discarded, no response is issued, and the reset values apply on the next cycle.

## Timing
- Accept at edge E: RUN applies rounds 0..ROUNDS at edges E+1..E+ROUNDS+1.
- resp_valid is high starting the cycle after edge E+ROUNDS+1, i.e. 11 edges after accept for ROUNDS=10.
- With resp_ready held high: response taken at edge E+ROUNDS+2, IDLE the following cycle, next accept at edge E+ROUNDS+3.
  - Sustained throughput: one block per ROUNDS+3 = 13 cycles.
- resp_ready high while resp_valid is low has no effect.
- A requester kept waiting by back-pressure keeps its round-robin priority. last_grant changes only on an accept.
- busy rises the cycle after accept and falls the cycle after the response handshake.

## Test plan
- FIPS-197 vector on req0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, bench round model on dp_result.
  - Required: resp_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp_id 0, resp_valid exactly 11 edges after accept.
- Both requesters valid every cycle from reset, resp_ready=1:
  - Grants alternate 0,1,0,1.
  - Accepts spaced 13 cycles apart.
  - Each resp_id matches its job.
- Back-pressure:
  - Stimulus: resp_ready=0 for 20 cycles after resp_valid rises.
  - Required: resp_data/resp_id stable; req0_ready and req1_ready stay 0; busy=1.
  - Required: after resp_ready=1 for one cycle, IDLE, and the next accept follows one cycle later.
- Input corruption:
  - Stimulus: change req0_block and req0_key every cycle after acceptance.
  - Required: ciphertext still matches the values latched at accept.
- Reset mid-operation:
  - Stimulus: assert rst at round 5 for 1 cycle.
  - Required: all outputs 0 the next cycle; no response ever issued for the aborted job; next tie goes to requester 0.
- ROUNDS=1 build:
  - Stimulus: one job.
  - Required: dp_round goes 0 then 1, dp_final high only in round 1, resp_valid 2 edges after accept.

Source files
------------

// File: rtl/aes_enc_scheduler.sv
// aes_enc_scheduler
//
// Sequencing and arbitration controller for a shared, purely combinational
// AES-128 round datapath. Two requesters hand in jobs over valid/ready; the
// controller grants them round-robin, latches plaintext and key, steps the
// round counter one round per clock and returns the ciphertext, tagged with
// the owning requester, on a valid/ready response channel.
//
// Parameters
//   ROUNDS      number of cipher rounds after the initial whitening (1..15)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            job handshake for requester N (N = 0, 1)
//   reqN_block, reqN_key        plaintext and cipher key of requester N
//   resp_valid/ready            response handshake
//   resp_id, resp_data          owning requester and ciphertext
//   dp_state, dp_key            state and latched key driven to the datapath
//   dp_round, dp_final          round index (0 = whitening) and last-round flag
//   dp_result                   combinational datapath output
//   busy                        high whenever a job is held
module aes_enc_scheduler #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic [127:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [127:0] resp_data,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic [3:0]   dp_round,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  fsm_t         fsm_r;
  fsm_t         fsm_nxt_s;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [3:0]   round_r;
  logic         id_r;
  logic         last_grant_r;

  logic         grant_s;
  logic         accept_s;
  logic         in_idle_s;
  logic         in_run_s;
  logic         in_done_s;
  logic         last_round_s;

  // State decode shared by the handshake, output and register logic.
  always_comb begin
    in_idle_s    = (fsm_r == IDLE);
    in_run_s     = (fsm_r == RUN);
    in_done_s    = (fsm_r == DONE);
    last_round_s = (round_r == LAST_ROUND);
  end

  // Round-robin choice: a lone requester wins; on a tie the one that was
  // not granted last time wins. last_grant_r only moves on an accept, so a
  // requester stalled by back-pressure keeps its turn.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Request handshakes; readies are only offered in IDLE and never together.
  always_comb begin
    req0_ready = in_idle_s & req0_valid & ~grant_s;
    req1_ready = in_idle_s & req1_valid & grant_s;
    accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // FSM next-state logic.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (accept_s) begin
          fsm_nxt_s = RUN;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_round_s) begin
          fsm_nxt_s = DONE;
        end else begin
          fsm_nxt_s = RUN;
        end
      end
      DONE: begin
        if (resp_ready) begin
          fsm_nxt_s = IDLE;
        end else begin
          fsm_nxt_s = DONE;
        end
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_nxt_s;
    end
  end

  // Job registers: latch on accept, fold in one datapath round per RUN cycle.
  // The round counter parks at LAST_ROUND through DONE and clears on the
  // response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= 128'd0;
      key_r        <= 128'd0;
      round_r      <= 4'd0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= grant_s ? req1_block : req0_block;
            key_r        <= grant_s ? req1_key : req0_key;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            round_r      <= 4'd0;
          end
        end
        RUN: begin
          state_r <= dp_result;
          if (!last_round_s) begin
            round_r <= round_r + 4'd1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            round_r <= 4'd0;
          end
        end
        default: begin
          round_r <= 4'd0;
        end
      endcase
    end
  end

  // Outputs are pure functions of the registers; the response fields are
  // gated so they read zero unless a response is actually offered.
  always_comb begin
    resp_valid = in_done_s;
    resp_data  = in_done_s ? state_r : 128'd0;
    resp_id    = in_done_s & id_r;
    dp_state   = state_r;
    dp_key     = key_r;
    dp_round   = round_r;
    dp_final   = in_run_s & last_round_s;
    busy       = ~in_idle_s;
  end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
module tb_aes_enc_scheduler;

  localparam int NR = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_block, req0_key, req1_block, req1_key;
  logic         resp_valid, resp_ready, resp_id;
  logic [127:0] resp_data, dp_state, dp_key, dp_result;
  logic [3:0]   dp_round;
  logic         dp_final, busy;

  logic         r1_req0_valid, r1_req0_ready, r1_req1_valid, r1_req1_ready;
  logic [127:0] r1_req0_block, r1_req0_key, r1_req1_block, r1_req1_key;
  logic         r1_resp_valid, r1_resp_ready, r1_resp_id;
  logic [127:0] r1_resp_data, r1_dp_state, r1_dp_key, r1_dp_result;
  logic [3:0]   r1_dp_round;
  logic         r1_dp_final, r1_busy;

  aes_enc_scheduler #(.ROUNDS(NR)) u0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .dp_state(dp_state), .dp_key(dp_key), .dp_round(dp_round), .dp_final(dp_final),
    .dp_result(dp_result), .busy(busy)
  );

  aes_enc_scheduler #(.ROUNDS(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(r1_req0_valid), .req0_ready(r1_req0_ready), .req0_block(r1_req0_block), .req0_key(r1_req0_key),
    .req1_valid(r1_req1_valid), .req1_ready(r1_req1_ready), .req1_block(r1_req1_block), .req1_key(r1_req1_key),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready), .resp_id(r1_resp_id), .resp_data(r1_resp_data),
    .dp_state(r1_dp_state), .dp_key(r1_dp_key), .dp_round(r1_dp_round), .dp_final(r1_dp_final),
    .dp_result(r1_dp_result), .busy(r1_busy)
  );

  // ---------------- AES reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, r;
    y = gmul(x, x);
    r = y;
    for (int i = 0; i < 6; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(getb(s, r + 4*((c+r)%4)));
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = getb(s, 4*c); a1 = getb(s, 4*c+1); a2 = getb(s, 4*c+2); a3 = getb(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [127:0] k;
    logic [31:0] t, w0, w1, w2, w3;
    logic [7:0] rc;
    k = key; rc = 8'h01;
    for (int j = 1; j <= r; j++) begin
      t = {k[23:0], k[31:24]};
      t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t; w1 = k[95:64] ^ w0; w2 = k[63:32] ^ w1; w3 = k[31:0] ^ w2;
      k = {w0, w1, w2, w3};
      rc = xt(rc);
    end
    return k;
  endfunction

  // One datapath step as the external round logic would compute it.
  function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [127:0] k,
                                            input logic [3:0] r, input logic f);
    logic [127:0] rk;
    rk = round_key(k, int'(r));
    if (r == 4'd0) return s ^ rk;
    if (f) return sub_shift(s) ^ rk;
    return mix(sub_shift(s)) ^ rk;
  endfunction

  // Whole encryption in one go.
  function automatic logic [127:0] aes_ref(input logic [127:0] b, input logic [127:0] k, input int nr);
    logic [127:0] s;
    s = b ^ k;
    for (int r = 1; r <= nr; r++) begin
      s = sub_shift(s);
      if (r != nr) s = mix(s);
      s = s ^ round_key(k, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb dp_result = dp_model(dp_state, dp_key, dp_round, dp_final);
  always_comb r1_dp_result = dp_model(r1_dp_state, r1_dp_key, r1_dp_round, r1_dp_final);

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  typedef struct {
    logic         id;
    logic [127:0] data;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  logic m_last, m_busy, prev_valid, prev_ready, prev_id;
  logic [127:0] prev_data;
  int acc_count = 0, last_acc_edge = 0, hs_edge = 0;
  logic last_acc_id = 1'b0;

  // Monitor/scoreboard: models arbitration and occupancy, pushes expected
  // ciphertexts at accept and compares them on response handshakes.
  initial begin
    exp_t e;
    logic g;
    m_last = 1'b1; m_busy = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    prev_id = 1'b0; prev_data = 128'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_last = 1'b1; m_busy = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
      end else begin
        chk("busy", busy, m_busy);
        chk("resp_valid", resp_valid, m_busy && sb.size() > 0 && cyc >= sb[0].edge_n + NR + 1);
        chk("ready_exclusive", req0_ready & req1_ready, 1'b0);
        if (resp_valid && prev_valid && !prev_ready) begin
          chk("hold_data", resp_data, prev_data);
          chk("hold_id", resp_id, prev_id);
        end
        if (resp_valid && resp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_id", resp_id, e.id);
          chk("resp_data", resp_data, e.data);
          m_busy = 1'b0;
          hs_edge = cyc + 1;
        end else if (m_busy) begin
          chk("ready_while_busy", req0_ready | req1_ready, 1'b0);
        end else if (req0_valid | req1_valid) begin
          g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
          chk("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
          e.id = g;
          e.data = g ? aes_ref(req1_block, req1_key, NR) : aes_ref(req0_block, req0_key, NR);
          e.edge_n = cyc + 1;
          sb.push_back(e);
          m_last = g; m_busy = 1'b1;
          acc_count++; last_acc_edge = cyc + 1; last_acc_id = g;
        end else begin
          chk("ready_no_valid", req0_ready | req1_ready, 1'b0);
        end
        prev_valid = resp_valid; prev_ready = resp_ready;
        prev_data = resp_data; prev_id = resp_id;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic scramble;

  task automatic tick();
    @(posedge clk);
    #1;
    if (scramble) begin
      req0_block = rand128(); req0_key = rand128();
      req1_block = rand128(); req1_key = rand128();
    end
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int target;
    target = acc_count + n;
    for (int i = 0; i < budget && acc_count < target; i++) tick();
    chk("accept_timeout", acc_count, target);
  endtask

  task automatic wait_resp(input int budget);
    for (int i = 0; i < budget && !resp_valid; i++) tick();
    chk("resp_timeout", resp_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || busy); i++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready0"}, req0_ready, 1'b0);
    chk({tag, "_ready1"}, req1_ready, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_id"}, resp_id, 1'b0);
    chk({tag, "_resp_data"}, resp_data, 128'd0);
    chk({tag, "_dp_state"}, dp_state, 128'd0);
    chk({tag, "_dp_key"}, dp_key, 128'd0);
    chk({tag, "_dp_round"}, dp_round, 4'd0);
    chk({tag, "_dp_final"}, dp_final, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int prev_edge;
    logic [127:0] b1, k1;
    rst = 1'b1; scramble = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_block = 128'd0; req0_key = 128'd0; req1_block = 128'd0; req1_key = 128'd0;
    r1_req0_valid = 1'b0; r1_req1_valid = 1'b0; r1_resp_ready = 1'b0;
    r1_req0_block = 128'd0; r1_req0_key = 128'd0; r1_req1_block = 128'd0; r1_req1_key = 128'd0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    chk("r1_reset_busy", r1_busy, 1'b0);
    chk("r1_reset_ready1", r1_req1_ready, 1'b0);

    // FIPS-197 vector on requester 0, inputs corrupted after accept.
    tick();
    req0_block = 128'h00112233445566778899aabbccddeeff;
    req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
    req0_valid = 1'b1; resp_ready = 1'b1;
    wait_accepts(1, 20);
    req0_valid = 1'b0; scramble = 1'b1;
    wait_resp(30);
    chk("fips_data", resp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips_id", resp_id, 1'b0);
    wait_idle(30);

    // Both requesters valid every cycle from reset.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    prev_edge = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accepts(1, 40);
      chk("alternate_grant", last_acc_id, i % 2);
      if (i > 0) chk("accept_spacing", last_acc_edge - prev_edge, NR + 3);
      prev_edge = last_acc_edge;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(40);

    // Back-pressure on the response channel.
    resp_ready = 1'b0; req0_valid = 1'b1;
    wait_accepts(1, 10);
    req0_valid = 1'b0;
    wait_resp(30);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_ready0", req0_ready, 1'b0);
      chk("bp_ready1", req1_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    wait_accepts(1, 5);
    chk("bp_next_accept", last_acc_edge, hs_edge + 1);
    chk("bp_next_id", last_acc_id, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    wait_idle(40);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      tick();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    wait_idle(60);

    // Reset in the middle of a job.
    req0_valid = 1'b1;
    wait_accepts(1, 10);
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && dp_round != 4'd5; i++) tick();
    chk("reach_round5", dp_round, 4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    repeat (15) tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_accepts(1, 5);
    chk("tie_after_reset", last_acc_id, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(40);
    scramble = 1'b0;

    // ROUNDS=1 instance.
    tick();
    b1 = rand128(); k1 = rand128();
    r1_req0_block = b1; r1_req0_key = k1;
    r1_req0_valid = 1'b1; r1_resp_ready = 1'b1;
    @(negedge clk);
    chk("r1_ready", r1_req0_ready, 1'b1);
    @(posedge clk); #1;
    r1_req0_valid = 1'b0;
    r1_req0_block = rand128(); r1_req0_key = rand128();
    @(negedge clk);
    chk("r1_round0", r1_dp_round, 4'd0);
    chk("r1_final0", r1_dp_final, 1'b0);
    chk("r1_valid0", r1_resp_valid, 1'b0);
    @(negedge clk);
    chk("r1_round1", r1_dp_round, 4'd1);
    chk("r1_final1", r1_dp_final, 1'b1);
    chk("r1_valid1", r1_resp_valid, 1'b0);
    @(negedge clk);
    chk("r1_valid2", r1_resp_valid, 1'b1);
    chk("r1_final2", r1_dp_final, 1'b0);
    chk("r1_data", r1_resp_data, aes_ref(b1, k1, 1));
    chk("r1_id", r1_resp_id, 1'b0);
    @(negedge clk);
    chk("r1_taken", r1_resp_valid, 1'b0);
    chk("r1_idle", r1_busy, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
